// File: rtl/fb_port_arbiter.sv
// Memory port scheduler for the VGA frame buffer. Active video reads one
// pixel per clock; the result writer is granted the port during blanking.
module fb_port_arbiter #(
  parameter int unsigned IMG_W  = 480,
  parameter int unsigned IMG_H  = 320,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        H_Count_Value,
  input  logic [9:0]        V_Count_Value,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] R,
  output logic [DATA_W-1:0] G,
  output logic [DATA_W-1:0] B,
  output logic              pix_valid,
  output logic              frame_done
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  // One extra bit so the limit is representable even when 2^ADDR_W == NPIX.
  localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);
  localparam logic [9:0]        H_LAST    = 10'(IMG_W - 1);
  localparam logic [9:0]        V_LAST    = 10'(IMG_H - 1);

  typedef enum logic [1:0] {BLANK, DISP, VSYNC_CLR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wr_err_q, wr_err_d;
  logic                frame_done_q, frame_done_d;
  logic [1:0]          vld_q;
  logic                pix_valid_q;
  logic [DATA_W-1:0]   pix_q;
  logic                active_c;
  logic                vblank_c;
  logic                wr_in_range_c;

  assign active_c      = (H_Count_Value <= H_LAST) && (V_Count_Value <= V_LAST);
  assign vblank_c      = (V_Count_Value > V_LAST);
  assign wr_in_range_c = ({1'b0, wr_addr} < NPIX_EXT);
  assign wr_ack        = wr_req && !active_c && !rst;

  // Next-state logic: vertical blanking overrides everything else.
  always_comb begin
    state_d = state_q;
    if (vblank_c) begin
      state_d = VSYNC_CLR;
    end else begin
      case (state_q)
        BLANK:     if (active_c)  state_d = DISP;
        DISP:      if (!active_c) state_d = BLANK;
        VSYNC_CLR: if (active_c)  state_d = DISP;
        default:   state_d = VSYNC_CLR;
      endcase
    end
  end

  // Port scheduling: reads own active cycles, writes fill blanking.
  always_comb begin
    rd_addr_d    = rd_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_err_d     = 1'b0;
    frame_done_d = 1'b0;
    if (active_c) begin
      mem_addr_d = rd_addr_q;
      if (rd_addr_q == LAST_ADDR) begin
        rd_addr_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
    end else begin
      if (state_q == VSYNC_CLR) rd_addr_d = '0;
      if (wr_ack) begin
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
        mem_we_d    = wr_in_range_c;
        wr_err_d    = !wr_in_range_c;
      end
    end
  end

  // State, port and output pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= VSYNC_CLR;
      rd_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wr_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
      vld_q        <= 2'b00;
      pix_valid_q  <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_err_q     <= wr_err_d;
      frame_done_q <= frame_done_d;
      vld_q        <= {vld_q[0], active_c};
      pix_valid_q  <= vld_q[1];
      pix_q        <= vld_q[1] ? mem_rdata : '0;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_err     = wr_err_q;
  assign frame_done = frame_done_q;
  assign pix_valid  = pix_valid_q;
  assign R          = pix_q;
  assign G          = pix_q;
  assign B          = pix_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter on a reduced frame (32x12 image in a 40x16 sweep).
module tb_fb_port_arbiter;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 12;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int H_TOT  = 40;
  localparam int V_TOT  = 16;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        H_Count_Value, V_Count_Value;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, wr_err, mem_we, pix_valid, frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, R, G, B;

  always #5 clk = ~clk;

  fb_port_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .R(R), .G(G), .B(B), .pix_valid(pix_valid), .frame_done(frame_done)
  );

  // Synchronous single-port memory, preloaded with value = address[7:0].
  logic [7:0] mem [0:MEMSZ-1];
  logic       mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'(i);
      mem_inited <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int         due;
    logic [7:0] val;
  } pix_t;

  typedef struct {
    int h; int v; int req; int a; int d; int ack;
  } vec_t;

  pix_t       q[$];
  vec_t       vec[9];
  logic [7:0] ref_mem [0:MEMSZ-1];
  int tests = 0, fails = 0;
  int cyc = 0, exp_addr = 0;
  bit in_vs = 1'b1, exp_fd = 1'b0, exp_we = 1'b0, exp_err = 1'b0, last_ack = 1'b0;
  int exp_maddr = 0, exp_wdata = 0;
  int fd_cnt = 0, pv_cnt = 0, we_cnt = 0, err_cnt = 0, ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one clock of inputs, update the reference model, check outputs.
  task automatic step(input int h, input int v, input int rq, input int a, input int d, input int r);
    bit act, e_ack;
    H_Count_Value = 10'(h);
    V_Count_Value = 10'(v);
    wr_req  = (rq != 0);
    wr_addr = ADDR_W'(a);
    wr_data = DATA_W'(d);
    rst     = (r != 0);
    #1;
    act   = (h < IMG_W) && (v < IMG_H);
    e_ack = (rq != 0) && !act && (r == 0);
    chk("wr_ack", 32'(wr_ack), 32'(e_ack));
    last_ack = wr_ack;
    if (wr_ack) ack_cnt++;
    if (r != 0) begin
      q.delete();
      exp_addr = 0; in_vs = 1'b1; exp_fd = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
      exp_maddr = 0; exp_wdata = 0;
    end else begin
      exp_fd = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
      if (act) begin
        q.push_back('{cyc + 3, ref_mem[exp_addr]});
        exp_maddr = exp_addr;
        if (exp_addr == NPIX - 1) begin
          exp_addr = 0;
          exp_fd   = 1'b1;
        end else begin
          exp_addr++;
        end
      end else if (in_vs) begin
        exp_addr = 0;
      end
      if (e_ack) begin
        exp_maddr = a;
        exp_wdata = d & 8'hff;
        if (a < NPIX) begin
          exp_we     = 1'b1;
          ref_mem[a] = 8'(d);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (v >= IMG_H) in_vs = 1'b1;
      else if (act)   in_vs = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("wr_err", 32'(wr_err), 32'(exp_err));
    chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
    chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
    if (frame_done) fd_cnt++;
    if (wr_err)     err_cnt++;
    if (mem_we)     we_cnt++;
    if (pix_valid)  pv_cnt++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pixel_R", 32'(R), 32'(q[0].val));
      chk("pixel_G", 32'(G), 32'(q[0].val));
      chk("pixel_B", 32'(B), 32'(q[0].val));
      void'(q.pop_front());
    end else begin
      chk("pix_valid_idle", 32'(pix_valid), 32'd0);
      chk("rgb_idle", 32'({R, G, B}), 32'd0);
    end
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) step(0, IMG_H + 1, 0, 0, 0, 0);
  endtask

  // Raster sweep; optional reset after rst_at reads, optional stop after stop_at reads.
  task automatic sweep(input int rst_at, input int stop_at);
    int  reads = 0;
    bit  did_rst = 1'b0;
    for (int vv = 0; vv < V_TOT; vv++) begin
      for (int hh = 0; hh < H_TOT; hh++) begin
        if (stop_at >= 0 && reads == stop_at) return;
        if (rst_at >= 0 && reads == rst_at && !did_rst) begin
          did_rst = 1'b1;
          step(hh, vv, 0, 0, 0, 1);
          chk("rst_flush_pix", 32'({pix_valid, R, G, B}), 32'd0);
          chk("rst_flush_port", 32'({mem_we, wr_err, frame_done, mem_addr}), 32'd0);
        end
        step(hh, vv, 0, 0, 0, 0);
        if (hh < IMG_W && vv < IMG_H) reads++;
      end
    end
  endtask

  initial begin
    int fd0, pv0, we0, ack0, err0, ack_h;
    bit got;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'(i);
    vec[0] = '{0,         0,         1, 5,    8'h11, 0};
    vec[1] = '{IMG_W-1,   0,         1, 5,    8'h11, 0};
    vec[2] = '{IMG_W,     0,         1, 6,    8'h22, 1};
    vec[3] = '{0,         IMG_H,     1, 7,    8'h33, 1};
    vec[4] = '{IMG_W-1,   IMG_H-1,   1, 8,    8'h44, 0};
    vec[5] = '{IMG_W,     IMG_H-1,   1, 9,    8'h55, 1};
    vec[6] = '{H_TOT-1,   V_TOT-1,   1, NPIX, 8'h66, 1};
    vec[7] = '{5,         3,         0, 0,    8'h00, 0};
    vec[8] = '{IMG_W+3,   2,         0, 0,    8'h00, 0};

    // Reset with a pending request: no grant, everything cleared.
    step(IMG_W, 0, 1, 3, 8'h77, 1);
    step(IMG_W, 0, 1, 3, 8'h77, 1);
    chk("reset_outputs", 32'({pix_valid, frame_done, wr_err, mem_we, R}), 32'd0);
    chk("reset_port", 32'({mem_addr, mem_wdata}), 32'd0);

    // Grant decode table.
    for (int i = 0; i < 9; i++) begin
      step(vec[i].h, vec[i].v, vec[i].req, vec[i].a, vec[i].d, 0);
      chk("table_ack", 32'(last_ack), 32'(vec[i].ack));
    end

    // Full frame: every pixel once, one frame_done.
    vblank(3);
    fd0 = fd_cnt; pv0 = pv_cnt;
    sweep(-1, -1);
    chk("frame_pixels", 32'(pv_cnt - pv0), 32'(NPIX));
    chk("frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);

    // Request held from late in line 5 is granted on the first blanking column.
    got = 1'b0; ack_h = -1;
    for (int hh = IMG_W - 10; hh < H_TOT; hh++) begin
      step(hh, 5, got ? 0 : 1, 50, 8'h5A, 0);
      if (last_ack && !got) begin
        got = 1'b1; ack_h = hh;
        chk("held_we", 32'(mem_we), 32'd1);
        chk("held_addr", 32'(mem_addr), 32'd50);
        chk("held_data", 32'(mem_wdata), 32'h5A);
      end
    end
    chk("held_ack_col", 32'(ack_h), 32'(IMG_W));

    // Eight back-to-back writes, then out-of-range writes (limit and all-ones).
    we0 = we_cnt; ack0 = ack_cnt; err0 = err_cnt;
    for (int i = 0; i < 8; i++) step(IMG_W + i, 6, 1, 100 + i, 8'hA0 + i, 0);
    step(IMG_W + 8, 6, 0, 0, 0, 0);
    chk("b2b_we_cnt", 32'(we_cnt - we0), 32'd8);
    chk("b2b_ack_cnt", 32'(ack_cnt - ack0), 32'd8);
    step(IMG_W + 9, 6, 1, NPIX, 8'hEE, 0);
    step(IMG_W + 10, 6, 0, 0, 0, 0);
    step(IMG_W + 11, 6, 1, MEMSZ - 1, 8'hEE, 0);
    step(IMG_W + 12, 6, 0, 0, 0, 0);
    chk("oor_err_cnt", 32'(err_cnt - err0), 32'd2);
    chk("oor_we_cnt", 32'(we_cnt - we0), 32'd8);
    chk("oor_mem_kept", 32'(mem[NPIX]), 32'(NPIX & 255));

    // Frame after writes reads them back.
    vblank(3);
    sweep(-1, -1);

    // Reset mid-frame, then the next frame must start at address 0.
    sweep(100, -1);
    fd0 = fd_cnt; pv0 = pv_cnt;
    sweep(-1, -1);
    chk("post_rst_pixels", 32'(pv_cnt - pv0), 32'(NPIX));
    chk("post_rst_fd", 32'(fd_cnt - fd0), 32'd1);

    // Partial frame abandoned into vertical blanking: no frame_done, restart at 0.
    fd0 = fd_cnt;
    sweep(-1, 200);
    vblank(4);
    chk("partial_no_fd", 32'(fd_cnt - fd0), 32'd0);
    sweep(-1, -1);
    chk("partial_next_fd", 32'(fd_cnt - fd0), 32'd1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
